// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a word-wide data memory.
// Each request runs IDLE -> ACCESS -> DONE and can fault without touching memory.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [1:0]  exc_code,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic [3:0]  mem_wbyte_enable,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load, is_store, illegal, out_of_range, misaligned, fault;
  logic [1:0]  fault_code;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [3:0]  st_en;
  logic [31:0] st_data;

  // Decode and fault classification work on the latched request only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101: is_load  = 1'b1;
      4'b1000, 4'b1001, 4'b1010:                   is_store = 1'b1;
      default: ;
    endcase
    illegal      = !(is_load || is_store);
    out_of_range = (addr_q >= MEM_LIMIT);
    case (op_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault = illegal || out_of_range || misaligned;
    if (illegal)           fault_code = 2'b11;
    else if (out_of_range) fault_code = 2'b10;
    else if (misaligned)   fault_code = 2'b01;
    else                   fault_code = 2'b00;
  end

  // Lane k of the memory word holds byte offset k (little-endian).
  always_comb begin
    ld_byte = mem_dout[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (op_q[1:0])
      2'b00:   ld_value = op_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_value = op_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_value = mem_dout;
    endcase
    case (op_q[1:0])
      2'b00: begin
        st_en   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_en   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      ACCESS: begin
        state_d = DONE;
        rdata_d = (is_load && !fault) ? ld_value : 32'h0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gates the strobes combinationally so an aborted access commits nothing.
  assign ready            = (state_q == IDLE);
  assign mem_we           = (state_q == ACCESS) && is_store && !fault && !reset;
  assign mem_wbyte_enable = mem_we ? st_en : 4'b0000;
  assign mem_din          = mem_we ? st_data : 32'h0;
  assign mem_addr         = (state_q == IDLE) ? 10'h0 : addr_q[11:2];
  assign done             = (state_q == DONE) && !reset;
  assign exc              = done && fault;
  assign exc_code         = done ? fault_code : 2'b00;
  assign rdata            = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// multi-cycle sequences, and random accesses checked against a byte-level model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        ready;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic [31:0] rdata;
  logic        exc;
  logic [1:0]  exc_code;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [3:0]  mem_wbyte_enable;
  logic [31:0] mem_dout;

  mem_access_unit #(.MEM_BYTES(4096)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .ready            (ready),
    .op               (op),
    .addr             (addr),
    .wdata            (wdata),
    .done             (done),
    .rdata            (rdata),
    .exc              (exc),
    .exc_code         (exc_code),
    .mem_addr         (mem_addr),
    .mem_din          (mem_din),
    .mem_we           (mem_we),
    .mem_wbyte_enable (mem_wbyte_enable),
    .mem_dout         (mem_dout)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT; loaded from init_words while mem_init is high.
  logic [31:0] mem [0:1023];
  logic [31:0] init_words [0:1023];
  logic        mem_init;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_words[i];
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if (mem_wbyte_enable[k]) mem[mem_addr][8*k +: 8] <= mem_din[8*k +: 8];
    end
  end

  // Reference model: a flat byte array, accesses computed from size/alignment rules.
  logic [7:0] ref_bytes [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ref_access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                            output logic [31:0] r, output logic e, output logic [1:0] c,
                            output int we);
    int          size;
    logic [31:0] v;
    r = 32'h0; e = 1'b0; c = 2'b00; we = 0;
    size = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
    if (!(o inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA})) c = 2'b11;
    else if (a >= 32'd4096)                                           c = 2'b10;
    else if ((a % size) != 0)                                         c = 2'b01;
    if (c != 2'b00) begin
      e = 1'b1;
      return;
    end
    if (o[3]) begin
      for (int i = 0; i < size; i++) ref_bytes[a + i] = w[8*i +: 8];
      we = 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[a + i];
      if (!o[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      r = v;
    end
  endtask

  logic [9:0]  acc_maddr;
  logic [3:0]  acc_en;
  logic [31:0] acc_din;

  task automatic wait_idle();
    int n = 0;
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1);
  endtask

  // Issues one request from a negedge; returns at the negedge where done is sampled.
  task automatic do_access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                           output logic [31:0] r, output logic e, output logic [1:0] c,
                           output int we_cnt);
    int n;
    wait_idle();
    op = o; addr = a; wdata = w; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 1;
    we_cnt = 0;
    while (!done && n < 8) begin
      check("mem_addr_busy", {22'h0, mem_addr}, {22'h0, a[11:2]});
      check("ready_busy", ready, 0);
      if (mem_we) begin
        we_cnt++;
        acc_maddr = mem_addr; acc_en = mem_wbyte_enable; acc_din = mem_din;
      end else begin
        check("wen_gated", mem_wbyte_enable, 0);
        check("din_gated", mem_din, 0);
      end
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 2);
    check("mem_we_in_done", mem_we, 0);
    r = rdata; e = exc; c = exc_code;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  code;
    int          we;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] r, er;
    logic        e, ee;
    logic [1:0]  c, ec;
    int          we, ewe;
    logic [3:0]  ro;
    logic [31:0] ra, rw;
    logic [3:0]  legal_ops [8];

    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
    for (int i = 0; i < 1024; i++) init_words[i] = $urandom;
    init_words[3] = 32'h11223344;
    init_words[5] = 32'h80FF7F01;
    init_words[8] = 32'hDEADBEEF;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = init_words[i][8*k +: 8];

    tbl.push_back('{4'h2, 32'h0C,   32'h0,        32'h1122AB44, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h0, 32'h16,   32'h0,        32'hFFFFFFFF, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h4, 32'h16,   32'h0,        32'h000000FF, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h1, 32'h16,   32'h0,        32'hFFFF80FF, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h5, 32'h16,   32'h0,        32'h000080FF, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h2, 32'h14,   32'h0,        32'h80FF7F01, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h0, 32'h14,   32'h0,        32'h00000001, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h1, 32'h15,   32'h0,        32'h0,        1'b1, 2'd1, 0});
    tbl.push_back('{4'h2, 32'h16,   32'h0,        32'h0,        1'b1, 2'd1, 0});
    tbl.push_back('{4'h9, 32'h03,   32'hFFFF,     32'h0,        1'b1, 2'd1, 0});
    tbl.push_back('{4'h2, 32'h1000, 32'h0,        32'h0,        1'b1, 2'd2, 0});
    tbl.push_back('{4'h7, 32'h0,    32'h0,        32'h0,        1'b1, 2'd3, 0});
    tbl.push_back('{4'hA, 32'h1001, 32'h0,        32'h0,        1'b1, 2'd2, 0});
    tbl.push_back('{4'hF, 32'h1001, 32'h0,        32'h0,        1'b1, 2'd3, 0});
    tbl.push_back('{4'h9, 32'h0E,   32'h1234CAFE, 32'h0,        1'b0, 2'd0, 1});
    tbl.push_back('{4'h2, 32'h0C,   32'h0,        32'hCAFEAB44, 1'b0, 2'd0, 0});
    tbl.push_back('{4'hA, 32'h10,   32'hA5A55A5A, 32'h0,        1'b0, 2'd0, 1});
    tbl.push_back('{4'h0, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h5, 32'h12,   32'h0,        32'h0000A5A5, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h1, 32'h10,   32'h0,        32'h00005A5A, 1'b0, 2'd0, 0});
    tbl.push_back('{4'h8, 32'h11,   32'h80,       32'h0,        1'b0, 2'd0, 1});
    tbl.push_back('{4'h2, 32'h10,   32'h0,        32'hA5A5805A, 1'b0, 2'd0, 0});
    tbl.push_back('{4'hA, 32'hFFC,  32'h01020304, 32'h0,        1'b0, 2'd0, 1});
    tbl.push_back('{4'h4, 32'hFFF,  32'h0,        32'h00000001, 1'b0, 2'd0, 0});

    // Reset and post-reset idle state.
    reset = 1'b1; mem_init = 1'b1; req = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_exc", exc, 0);
    check("rst_exc_code", exc_code, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_wen", mem_wbyte_enable, 0);

    // SB lane steering and replication.
    ref_access(4'h8, 32'h0D, 32'h123456AB, er, ee, ec, ewe);
    acc_maddr = '0; acc_en = '0; acc_din = '0;
    do_access(4'h8, 32'h0D, 32'h123456AB, r, e, c, we);
    check("sb_we_count", we, 1);
    check("sb_mem_addr", acc_maddr, 3);
    check("sb_wen", acc_en, 4'b0010);
    check("sb_din", acc_din, 32'hABABABAB);
    check("sb_rdata", r, 0);
    check("sb_exc", e, 0);

    // Directed vector table.
    foreach (tbl[i]) begin
      ref_access(tbl[i].op, tbl[i].addr, tbl[i].wdata, er, ee, ec, ewe);
      do_access(tbl[i].op, tbl[i].addr, tbl[i].wdata, r, e, c, we);
      check($sformatf("vec%0d_rdata", i), r, tbl[i].rdata);
      check($sformatf("vec%0d_exc", i), e, tbl[i].exc);
      check($sformatf("vec%0d_code", i), c, tbl[i].code);
      check($sformatf("vec%0d_we", i), we, tbl[i].we);
    end

    // Back-to-back: req held high, second request waits for ready.
    wait_idle();
    ref_access(4'hA, 32'h40, 32'h5EED1234, er, ee, ec, ewe);
    ref_access(4'h2, 32'h40, 32'h0, er, ee, ec, ewe);
    op = 4'hA; addr = 32'h40; wdata = 32'h5EED1234; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 4'h2;
    check("b2b_ready_access", ready, 0);
    @(negedge clk);
    check("b2b_ready_done", ready, 0);
    check("b2b_sw_done", done, 1);
    @(negedge clk);
    check("b2b_ready_idle", ready, 1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("b2b_lw_accepted", ready, 0);
    @(negedge clk);
    check("b2b_lw_done", done, 1);
    check("b2b_lw_rdata", rdata, er);

    // Reset during the ACCESS cycle of a store aborts it.
    wait_idle();
    op = 4'hA; addr = 32'h20; wdata = 32'h55AA55AA; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("abort_we_before_reset", mem_we, 1);
    reset = 1'b1;
    #1;
    check("abort_we_in_reset", mem_we, 0);
    check("abort_done_in_reset", done, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_after", ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end
    check("abort_word8", mem[8], 32'hDEADBEEF);

    // Random accesses against the reference model.
    for (int i = 0; i < 120; i++) begin
      ro = legal_ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = 32'd4096 + $urandom_range(0, 15);
        default: ra = $urandom_range(0, 4095);
      endcase
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      rw = $urandom;
      ref_access(ro, ra, rw, er, ee, ec, ewe);
      do_access(ro, ra, rw, r, e, c, we);
      check($sformatf("rnd%0d_rdata op=%h a=%h", i, ro, ra), r, er);
      check($sformatf("rnd%0d_exc", i), e, ee);
      check($sformatf("rnd%0d_code", i), c, ec);
      check($sformatf("rnd%0d_we", i), we, ewe);
    end

    // Whole-memory comparison against the model.
    @(negedge clk);
    for (int i = 0; i < 1024; i++)
      check($sformatf("mem_word%0d", i), mem[i],
            {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_BYTES, default 4096, data-memory size in bytes; byte addresses >= MEM_BYTES are out of range.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  1  pipeline requests an access; sampled only while ready=1.
REQ-005 ready  out  1  unit idle, can accept req.
REQ-006 op  in  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes illegal.
REQ-007 addr  in  32  byte address of access.
REQ-008 wdata  in  32  store data, right-justified.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 rdata  out  32  extended load result; valid while done=1.
REQ-011 exc  out  1  access faulted; valid while done=1.
REQ-012 exc_code  out  2  01 misaligned, 10 out of range, 11 illegal op, 00 none.
REQ-013 mem_addr  out  10  word address (byte address bits 11:2) to data memory.
REQ-014 mem_din  out  32  lane-replicated store data to data memory.
REQ-015 mem_we  out  1  data-memory write enable.
REQ-016 mem_wbyte_enable  out  4  per-lane write enable; bit k covers bits 8k+7:8k.
REQ-017 mem_dout  in  32  combinational read data of word mem_addr.

Function
REQ-018 FSM SHALL have states IDLE, ACCESS, DONE; ready=1 only in IDLE.
REQ-019 IDLE with req=1: latch op, addr, wdata; next state ACCESS. req=0: stay IDLE.
REQ-020 ACCESS -> DONE unconditionally; DONE -> IDLE unconditionally; request accept to done = 2 cycles, throughput one access per 3 cycles.
REQ-021 Fault check on latched values, priority illegal op > out of range > misaligned.
REQ-022 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00.
REQ-023 mem_addr SHALL equal latched addr[11:2] in ACCESS and DONE, 0 in IDLE.
REQ-024 mem_we = (state==ACCESS) and store op and no fault and reset=0; high for exactly one cycle per good store.
REQ-025 Byte lane = little-endian: byte offset k maps to lane k.
REQ-026 SB: enable = 1<<addr[1:0], mem_din = byte replicated to 4 lanes.
REQ-027 SH: enable 0011 (addr[1]=0) or 1100 (addr[1]=1), mem_din = halfword replicated twice; SW: enable 1111, mem_din = wdata.
REQ-028 mem_wbyte_enable and mem_din SHALL be 0 whenever mem_we=0.
REQ-029 Loads: in ACCESS, capture selected lane(s) of mem_dout into rdata register; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-030 Stores and faulted accesses SHALL leave rdata = 0 at done.
REQ-031 Faulted access: no memory write, still passes ACCESS and DONE (same 2-cycle latency), done=1 with exc=1 and exc_code set.
REQ-032 done, exc, exc_code SHALL be 1/valid only in DONE, 0 otherwise; req in ACCESS/DONE ignored.

Reset
REQ-033 reset=1 at a clock edge: state IDLE, rdata 0, latched op/addr/wdata 0, exc 0, exc_code 00.
REQ-034 While reset=1 mem_we, done SHALL be 0 combinationally; reset in ACCESS aborts, no write committed, no done pulse.
REQ-035 First cycle after reset release: ready=1, all other outputs 0.

Verification
REQ-036 Memory word 5 = 0x80FF7F01; LB addr 0x16 -> done at cycle 2, rdata 0xFFFFFFFF (lane 2 = 0xFF), exc 0; LBU same addr -> 0x000000FF; LH addr 0x16 -> 0xFFFF80FF.
REQ-037 SB addr 0x0D wdata 0x123456AB -> in ACCESS mem_addr 3, mem_wbyte_enable 0010, mem_din 0xABABABAB, mem_we 1 for one cycle; subsequent LW 0x0C shows only bits 15:8 = 0xAB changed.
REQ-038 SH addr 0x0003 -> done with exc 1, exc_code 01, mem_we never 1; LW addr 0x1000 -> exc_code 10; op 0111 -> exc_code 11.
REQ-039 Back-to-back: req held high with SW then LW same address -> second accepted only when ready returns (3 cycles after first accept), LW returns SW data.
REQ-040 Assert reset during ACCESS of SW 0x20 -> mem_we 0, no done, memory word 8 unchanged, ready=1 next cycle.
